cdc_fifo_src_arbiter: RTL and testbench
=======================================

Name: cdc_fifo_src_arbiter

Overview:
- Round-robin, packet-locking arbiter sharing one CDC FIFO source port between NUM_REQ valid/ready requesters in the source clock domain.
- Each beat is tagged with the winning requester index so the destination side can demultiplex.
- A requester holds the grant until its last beat, or until MAX_BURST beats, whichever comes first.
- One registered output stage drives the FIFO source port; the FIFO data word is {idx, last, data}.

Parameters:
- NUM_REQ, 4, number of requesters (>=2, need not be a power of two)
- WIDTH, 32, payload width per beat
- MAX_BURST, 8, maximum beats per grant before forced re-arbitration (>=1)
- IDX_W, $clog2(NUM_REQ), width of requester index (derived localparam)

Ports:
- clk_i  in  1  source-domain clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  NUM_REQ  per-requester beat valid
- req_data_i  in  NUM_REQ*WIDTH  per-requester payload
- req_last_i  in  NUM_REQ  per-requester last beat of packet
- req_ready_o  out  NUM_REQ  per-requester beat accepted
- out_valid_o  out  1  to FIFO src_valid_i
- out_data_o  out  WIDTH  payload to FIFO
- out_idx_o  out  IDX_W  requester index of the beat
- out_last_o  out  1  copy of req_last_i of the beat
- out_ready_i  in  1  from FIFO src_ready_o
- busy_o  out  1  high while in LOCKED state
- grant_o  out  IDX_W  currently locked requester (valid when busy_o)

Behaviour:
- Reset values (asynchronous on rst_i high):
  - out_valid_o=0, out_data_o=0, out_idx_o=0, out_last_o=0
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0
  - busy_o=0, grant_o=0
- Output stage: register accepts a beat when adv = !out_valid_o || out_ready_i.
  - Beat on req i: req_valid_i[i] & req_ready_o[i].
  - Latency: one clock from accepted input beat to out_valid_o.
  - Throughput: one beat per cycle with out_ready_i held high.
- adv & no beat: out_valid_o<=0.
- Hold rule: while out_valid_o & !out_ready_i, out_data_o, out_idx_o and out_last_o are stable.
- req_ready_o[i] = adv & (i == sel). All other readies are 0. req_ready_o may depend combinationally on req_valid_i.
- sel in IDLE is the first i with req_valid_i[i]=1, searching i = rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ. If no valid, no beat.
- sel in LOCKED is grant; other requesters are not served even if valid.
- State machine:
  - IDLE, beat from sel with req_last_i=1 or MAX_BURST==1: stay IDLE, rr_ptr<=(sel+1) mod NUM_REQ.
  - IDLE, beat from sel otherwise: go to LOCKED, grant<=sel, beat_cnt<=1.
  - LOCKED, beat with req_last_i=1 or beat_cnt==MAX_BURST-1: go to IDLE, rr_ptr<=(grant+1) mod NUM_REQ, beat_cnt<=0.
  - LOCKED, beat otherwise: beat_cnt<=beat_cnt+1.
  - LOCKED, no beat (requester bubble or back-pressure): hold state; the grant is never revoked while waiting.
- Burst truncation: a burst-limit exit does not alter out_last_o; the packet resumes on a later grant. Ordering per requester is preserved.
- Wrap: rr_ptr = NUM_REQ-1 with next grant -> rr_ptr=0. This must hold for non-power-of-two NUM_REQ: no out-of-range index is ever produced.
- Widths: beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1. rr_ptr and grant are IDX_W bits.
- Reset mid-packet: everything returns to the reset values. Any beat in the output register is discarded. Protocol recovery is owned upstream.

Decomposition:
- Package cdc_arb_pkg holds:
  - state enum arb_state_e {IDLE, LOCKED}
  - a parameterised beat struct {idx, last, data} used as the FIFO T
- Sub-module rr_arb_pick (combinational): inputs valid vector and start pointer; outputs found flag and selected index, with modular wrap.
- Top holds the FSM, counters and output register.

Test Plan:
- Reset: assert rst_i mid-packet with out_valid_o=1 -> all outputs 0 in the same cycle; after release, req 0 single beat last=1 appears at out after 1 clk with idx=0.
- Round robin: NUM_REQ=4, all valid, all single-beat last=1, out_ready_i=1 -> idx sequence 0,1,2,3,0,1, one beat per cycle.
- Packet lock: req1 4-beat packet, req2 valid throughout -> out idx 1,1,1,1 then 2; req_ready_o[2]=0 during the lock, including req1 bubble cycles.
- Burst limit: MAX_BURST=2, req0 5-beat packet, req3 valid -> idx 0,0,3,0,0,3,0; out_last_o=1 only on the 5th req0 beat.
- Back-pressure: out_ready_i=0 for 3 cycles with out_valid_o=1 -> out_data/idx/last stable, all req_ready_o=0; resume -> no beat lost or duplicated (check via scoreboard).
- Wrap with NUM_REQ=3: grants idx 2 then only req0 valid -> rr_ptr wraps to 0 and idx=0 is granted; idx never equals 3.

Source files
------------

// File: rtl/cdc_arb_pkg.sv
// Shared types for the CDC FIFO source arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cdc_arb_pkg;

    // Arbiter FSM: IDLE picks round-robin, LOCKED serves one requester.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Default configuration of the FIFO word.
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_IDX_W   = $clog2(DEF_NUM_REQ);

    // FIFO element {idx, last, data} for the default configuration. The top
    // re-declares the same layout with its own parameter values.
    typedef struct packed {
        logic [DEF_IDX_W-1:0] idx;
        logic                 last;
        logic [DEF_WIDTH-1:0] data;
    } beat_t;

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin picker: first set bit of valid_i at or after start_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; found_o low when no bit is set.
module rr_arb_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest valid one wins;
    // the wrap subtracts N so non-power-of-two N never yields index N.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, start_i} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N)) begin
                cand = cand - (IDX_W + 1)'(N);
            end
            if (valid_i[cand[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cdc_fifo_src_arbiter.sv
// Round-robin packet-locking arbiter feeding one CDC FIFO source port.
// Latency: one clock from accepted request beat to out_valid_o.
// Backpressure: readies follow the output register; full-rate when out_ready_i stays high.
module cdc_fifo_src_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     out_valid_o,
    output logic [WIDTH-1:0]         out_data_o,
    output logic [IDX_W-1:0]         out_idx_o,
    output logic                     out_last_o,
    input  logic                     out_ready_i,
    output logic                     busy_o,
    output logic [IDX_W-1:0]         grant_o
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             last;
        logic [WIDTH-1:0] data;
    } out_beat_t;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             out_valid_q, out_valid_d;
    out_beat_t        out_beat_q, out_beat_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_ok;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             adv;
    logic             beat;

    // Successor index with explicit wrap so no out-of-range value appears.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    rr_arb_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i (req_valid_i),
        .start_i (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Choose the served requester and detect an accepted beat this cycle.
    always_comb begin
        adv = !out_valid_q || out_ready_i;
        if (state_q == LOCKED) begin
            sel_idx = grant_q;
            sel_ok  = 1'b1;
        end else begin
            sel_idx = pick_idx;
            sel_ok  = pick_found;
        end
        sel_last = req_last_i[sel_idx];
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_data = req_data_i[i*WIDTH +: WIDTH];
            end
        end
        beat = adv && sel_ok && req_valid_i[sel_idx];
    end

    // FSM next state: lock on a multi-beat packet, release on last beat or burst limit.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (sel_last || (MAX_BURST == 1)) begin
                        rr_ptr_d = next_idx(sel_idx);
                    end else begin
                        state_d    = LOCKED;
                        grant_d    = sel_idx;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (beat) begin
                    if (sel_last || (beat_cnt_q == BURST_END)) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_idx(grant_q);
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: single ready to the served requester, lock status.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = adv && sel_ok && (sel_idx == IDX_W'(i));
        end
        busy_o  = (state_q == LOCKED);
        grant_o = grant_q;
    end

    // Output register: load on advance, hold contents while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        if (adv) begin
            out_valid_d = beat;
            if (beat) begin
                out_beat_d.idx  = sel_idx;
                out_beat_d.last = sel_last;
                out_beat_d.data = sel_data;
            end
        end
    end

    // State, counters and output register; reset drops any held beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_beat_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_beat_q  <= out_beat_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_beat_q.data;
    assign out_idx_o   = out_beat_q.idx;
    assign out_last_o  = out_beat_q.last;

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Bench for cdc_fifo_src_arbiter with three requesters and a three-beat burst limit.
// Latency: expected beats are queued on acceptance and matched one clock later.
// Backpressure: out_ready_i is randomised per phase to exercise stalls.
module tb_cdc_fifo_src_arbiter;

    localparam int NR = 3;
    localparam int W  = 16;
    localparam int MB = 3;
    localparam int IW = $clog2(NR);

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR*W-1:0]   req_data_i;
    logic [NR-1:0]     req_last_i;
    logic [NR-1:0]     req_ready_o;
    logic              out_valid_o;
    logic [W-1:0]      out_data_o;
    logic [IW-1:0]     out_idx_o;
    logic              out_last_o;
    logic              out_ready_i;
    logic              busy_o;
    logic [IW-1:0]     grant_o;

    cdc_fifo_src_arbiter #(
        .NUM_REQ   (NR),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_idx_o   (out_idx_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .grant_o     (grant_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Per-requester pending beats {last, data} and the expected output stream {idx, last, data}.
    logic [W:0]    src_q[NR][$];
    logic [IW+W:0] exp_q[$];
    bit   [NR-1:0] vld;
    int            p_vld = 100;
    int            p_rdy = 100;
    int            seq   = 0;

    // Reference arbitration state: owner of the lock (-1 = none), beats granted in
    // the current lock, round-robin starting point, and whether the output slot is full.
    int owner     = -1;
    int bcnt      = 0;
    int ptr       = 0;
    bit slot_full = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic add_pkt(input int r, input int len);
        logic [W-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = {r[3:0], seq[11:0]};
            seq++;
            src_q[r].push_back({(b == len - 1), d});
        end
    endtask

    function automatic int pending();
        int n = exp_q.size();
        for (int i = 0; i < NR; i++) n += src_q[i].size();
        return n;
    endfunction

    // One clock: drive new inputs after the edge, predict and check at the falling edge.
    task automatic step();
        bit            adv_m;
        bit            take;
        int            sel;
        int            c;
        logic [NR-1:0] er;
        logic [W:0]    b;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (!vld[i] && src_q[i].size() > 0 && $urandom_range(99) < p_vld) vld[i] = 1'b1;
            req_valid_i[i] = vld[i];
            if (vld[i]) {req_last_i[i], req_data_i[i*W +: W]} = src_q[i][0];
            else begin
                req_last_i[i]       = 1'b0;
                req_data_i[i*W +: W] = '0;
            end
        end
        out_ready_i = ($urandom_range(99) < p_rdy);
        @(negedge clk);
        adv_m = !slot_full || out_ready_i;
        sel   = -1;
        if (owner >= 0) sel = owner;
        else begin
            for (int k = 0; k < NR; k++) begin
                c = (ptr + k) % NR;
                if (vld[c] && sel < 0) sel = c;
            end
        end
        er = '0;
        if (adv_m && sel >= 0) er[sel] = 1'b1;
        chk("req_ready", req_ready_o, er);
        chk("out_valid", out_valid_o, slot_full);
        chk("busy", busy_o, (owner >= 0));
        if (owner >= 0) chk("grant", grant_o, owner);
        take = adv_m && sel >= 0 && vld[sel];
        if (take) begin
            b = src_q[sel].pop_front();
            exp_q.push_back({sel[IW-1:0], b});
            vld[sel] = 1'b0;
            if (owner < 0) begin
                if (b[W] || MB == 1) ptr = (sel + 1) % NR;
                else begin
                    owner = sel;
                    bcnt  = 1;
                end
            end else if (b[W] || bcnt == MB - 1) begin
                ptr   = (owner + 1) % NR;
                owner = -1;
                bcnt  = 0;
            end else begin
                bcnt++;
            end
        end
        if (take) slot_full = 1'b1;
        else if (adv_m) slot_full = 1'b0;
    endtask

    task automatic drain(input int pv, input int pr);
        int n = 0;
        p_vld = pv;
        p_rdy = pr;
        while (pending() > 0 && n < 3000) begin
            step();
            n++;
        end
        chk("drained", pending(), 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_out_idx", out_idx_o, 0);
        chk("rst_out_last", out_last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
    endtask

    // Monitor: every beat the FIFO takes must be the next expected one.
    always @(negedge clk) begin
        if (!rst_i && out_valid_o) begin
            chk("idx_range", (out_idx_o < NR), 1);
            if (out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got idx %0d data 0x%0h, expected none", out_idx_o, out_data_o);
                end else begin
                    chk("beat", {out_idx_o, out_last_o, out_data_o}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int  n;
        bit  hit;
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        out_ready_i = 1'b1;
        vld         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_i = 1'b0;

        // Round robin with single-beat packets, including the 2 -> 0 wrap.
        for (int k = 0; k < 4; k++) for (int r = 0; r < NR; r++) add_pkt(r, 1);
        drain(100, 100);

        // Packet lock with requester bubbles while another requester waits.
        add_pkt(1, 4);
        for (int k = 0; k < 3; k++) add_pkt(2, 1);
        drain(60, 100);

        // Burst limit splits long packets; last flag stays with the true last beat.
        add_pkt(0, 5);
        for (int k = 0; k < 3; k++) add_pkt(2, 1);
        drain(100, 100);
        add_pkt(0, 7);
        add_pkt(1, 2);
        drain(70, 60);

        // Heavy back-pressure.
        for (int r = 0; r < NR; r++) add_pkt(r, 4);
        drain(90, 25);

        // Wrap: requester 2 then only requester 0.
        add_pkt(2, 1);
        drain(100, 100);
        add_pkt(0, 1);
        drain(100, 100);

        // Randomised mix.
        p_vld = 70;
        p_rdy = 70;
        for (int t = 0; t < 400; t++) begin
            for (int r = 0; r < NR; r++) begin
                if (src_q[r].size() < 8 && $urandom_range(9) == 0) add_pkt(r, $urandom_range(1, 6));
            end
            step();
        end
        drain(80, 80);

        // Reset in the middle of a locked packet with a beat in the output register.
        add_pkt(0, 6);
        add_pkt(1, 3);
        p_vld = 100;
        p_rdy = 50;
        hit   = 1'b0;
        n     = 0;
        while (!hit && n < 100) begin
            step();
            hit = out_valid_o && (owner >= 0);
            n++;
        end
        chk("reset_setup", hit, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        for (int i = 0; i < NR; i++) src_q[i].delete();
        vld         = '0;
        owner       = -1;
        bcnt        = 0;
        ptr         = 0;
        slot_full   = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        add_pkt(0, 1);
        drain(100, 100);
        add_pkt(1, 2);
        add_pkt(2, 1);
        drain(100, 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
